// File: rtl/i2c_slave_stream.sv
// I2C target with a fixed 7-bit address: write bytes leave on a ready/valid stream,
// read bytes are fetched from a ready/valid stream. Open-drain SDA, no clock stretching.
module i2c_slave_stream #(
   parameter int         DATA_DEPTH = 8,
   parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_scl,
   input  logic                  i_sda,
   output logic                  o_sda_oe,
   output logic                  o_sda,
   output logic [DATA_DEPTH-1:0] o_rx_bits,
   output logic                  o_rx_valid,
   input  logic                  i_rx_ready,
   input  logic [DATA_DEPTH-1:0] i_tx_bits,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic                  o_busy,
   output logic                  o_underflow
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
   } state_t;

   localparam logic [3:0] LAST_BIT = 4'(DATA_DEPTH - 1);
   localparam logic [3:0] ACK_SLOT = 4'(DATA_DEPTH);

   state_t                state, state_n;
   logic [3:0]            bit_cnt, cnt_n;
   logic [DATA_DEPTH-1:0] shift, shift_n;
   logic [DATA_DEPTH-1:0] rx_bits_n;
   logic                  sda_oe, oe_n;
   logic                  ack_ok, ack_n;
   logic                  rw, rw_n;
   logic                  rx_valid_n;
   logic                  tx_fetch;
   logic                  scl_s1, scl_s2, scl_d;
   logic                  sda_s1, sda_s2, sda_d;
   logic                  scl_rise, scl_fall, start_det, stop_det, rx_free;

   // Synchronizers idle high so a reset never fabricates a bus event.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         {scl_s1, scl_s2, scl_d} <= 3'b111;
         {sda_s1, sda_s2, sda_d} <= 3'b111;
      end else begin
         {scl_s1, scl_s2, scl_d} <= {i_scl, scl_s1, scl_s2};
         {sda_s1, sda_s2, sda_d} <= {i_sda, sda_s1, sda_s2};
      end
   end

   assign scl_rise  = scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 & scl_d;
   assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
   assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
   assign rx_free   = ~o_rx_valid | i_rx_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         sda_oe     <= 1'b0;
         ack_ok     <= 1'b0;
         rw         <= 1'b0;
         o_rx_bits  <= '0;
         o_rx_valid <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= cnt_n;
         shift      <= shift_n;
         sda_oe     <= oe_n;
         ack_ok     <= ack_n;
         rw         <= rw_n;
         o_rx_bits  <= rx_bits_n;
         o_rx_valid <= rx_valid_n;
      end
   end

   // In the ACK states bit_cnt==ACK_SLOT means "waiting for the fall that opens the slot".
   always_comb begin
      state_n    = state;
      cnt_n      = bit_cnt;
      shift_n    = shift;
      oe_n       = sda_oe;
      ack_n      = ack_ok;
      rw_n       = rw;
      rx_bits_n  = o_rx_bits;
      rx_valid_n = o_rx_valid & ~i_rx_ready;
      tx_fetch   = 1'b0;
      if (start_det) begin
         state_n = ADDR;
         cnt_n   = '0;
         oe_n    = 1'b0;
      end else if (stop_det) begin
         state_n = IDLE;
         cnt_n   = '0;
         oe_n    = 1'b0;
      end else begin
         case (state)
            ADDR: if (scl_rise) begin
               shift_n = {shift[DATA_DEPTH-2:0], sda_s2};
               cnt_n   = bit_cnt + 4'd1;
               if (bit_cnt == LAST_BIT) begin
                  rw_n    = sda_s2;
                  state_n = (shift[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
               end
            end
            ADDR_ACK: if (scl_fall) begin
               cnt_n = '0;
               if (bit_cnt == ACK_SLOT) begin
                  oe_n = 1'b1;
               end else if (rw) begin
                  tx_fetch = 1'b1;
                  state_n  = RD_DATA;
               end else begin
                  oe_n    = 1'b0;
                  state_n = WR_DATA;
               end
            end
            WR_DATA: if (scl_rise) begin
               shift_n = {shift[DATA_DEPTH-2:0], sda_s2};
               cnt_n   = bit_cnt + 4'd1;
               if (bit_cnt == LAST_BIT) begin
                  state_n = WR_ACK;
                  ack_n   = rx_free;
                  if (rx_free) begin
                     rx_bits_n  = {shift[DATA_DEPTH-2:0], sda_s2};
                     rx_valid_n = 1'b1;
                  end
               end
            end
            WR_ACK: if (scl_fall) begin
               cnt_n = '0;
               if (bit_cnt == ACK_SLOT) begin
                  oe_n = ack_ok;
               end else begin
                  oe_n    = 1'b0;
                  state_n = ack_ok ? WR_DATA : WAIT_STOP;
               end
            end
            RD_DATA: begin
               if (scl_rise) begin
                  shift_n = {shift[DATA_DEPTH-2:0], 1'b1};
                  cnt_n   = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == ACK_SLOT) begin
                     oe_n    = 1'b0;
                     cnt_n   = '0;
                     state_n = RD_ACK;
                  end else begin
                     oe_n = ~shift[DATA_DEPTH-1];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  if (!sda_s2) cnt_n = ACK_SLOT;
                  else state_n = WAIT_STOP;
               end else if (scl_fall && bit_cnt == ACK_SLOT) begin
                  cnt_n    = '0;
                  tx_fetch = 1'b1;
                  state_n  = RD_DATA;
               end
            end
            default: oe_n = 1'b0;
         endcase
      end
      // A fetch also puts the new MSB on the bus straight away.
      if (tx_fetch) begin
         shift_n = i_tx_valid ? i_tx_bits : '1;
         oe_n    = ~shift_n[DATA_DEPTH-1];
      end
   end

   assign o_sda       = 1'b0;
   assign o_sda_oe    = sda_oe;
   assign o_tx_ready  = tx_fetch;
   assign o_underflow = tx_fetch & ~i_tx_valid;
   assign o_busy      = (state == ADDR_ACK) || (state == WR_DATA) || (state == WR_ACK) ||
                        (state == RD_DATA)  || (state == RD_ACK);

endmodule

// File: tb/tb_i2c_slave_stream.sv
// Directed bench for i2c_slave_stream: the bench acts as bus master on an open-drain SDA line.
module tb_i2c_slave_stream;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_scl = 1'b1;
   logic       master_sda = 1'b1;
   logic       i_rx_ready = 1'b1;
   logic [7:0] i_tx_bits = 8'h00;
   logic       i_tx_valid = 1'b0;
   logic       o_sda_oe, o_sda, o_rx_valid, o_tx_ready, o_busy, o_underflow;
   logic [7:0] o_rx_bits;
   wire        sda_line;

   assign sda_line = master_sda & ~o_sda_oe;

   i2c_slave_stream dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_scl(i_scl), .i_sda(sda_line),
      .o_sda_oe(o_sda_oe), .o_sda(o_sda), .o_rx_bits(o_rx_bits), .o_rx_valid(o_rx_valid),
      .i_rx_ready(i_rx_ready), .i_tx_bits(i_tx_bits), .i_tx_valid(i_tx_valid),
      .o_tx_ready(o_tx_ready), .o_busy(o_busy), .o_underflow(o_underflow)
   );

   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;
   int tx_ready_cnt = 0, underflow_cnt = 0, rx_pulse_cnt = 0, oe_cycles = 0, busy_cycles = 0;
   logic rx_valid_q = 1'b0;
   logic [7:0] rx_log[$];

   // Event counters and the log of consumed rx bytes, sampled mid-cycle.
   always @(negedge i_clk) begin
      if (o_tx_ready) tx_ready_cnt++;
      if (o_underflow) underflow_cnt++;
      if (o_sda_oe) oe_cycles++;
      if (o_busy) busy_cycles++;
      if (o_rx_valid && !rx_valid_q) rx_pulse_cnt++;
      rx_valid_q = o_rx_valid;
      if (o_rx_valid && i_rx_ready) rx_log.push_back(o_rx_bits);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic bus_start();
      master_sda = 1'b1; tick(10);
      i_scl = 1'b1;      tick(10);
      master_sda = 1'b0; tick(10);
      i_scl = 1'b0;      tick(10);
   endtask

   task automatic bus_stop();
      master_sda = 1'b0; tick(10);
      i_scl = 1'b1;      tick(10);
      master_sda = 1'b1; tick(10);
   endtask

   task automatic bus_bit(input logic b, output logic r);
      master_sda = b; tick(10);
      i_scl = 1'b1;   tick(5);
      r = sda_line;   tick(5);
      i_scl = 1'b0;   tick(10);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic nak);
      logic r;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
      bus_bit(1'b1, nak);
   endtask

   task automatic read_byte(input logic master_nak, output logic [7:0] d);
      logic r;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         bus_bit(1'b1, r);
         d = {d[6:0], r};
      end
      bus_bit(master_nak, r);
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      tick(4);
      tests++; if (o_sda_oe !== 1'b0) begin fails++; $display("[TB] FAIL reset_oe: got %b expected 0", o_sda_oe); end
      tests++; if (o_sda !== 1'b0) begin fails++; $display("[TB] FAIL reset_sda: got %b expected 0", o_sda); end
      tests++; if (o_rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", o_rx_valid); end
      tests++; if (o_rx_bits !== 8'h00) begin fails++; $display("[TB] FAIL reset_rx_bits: got %h expected 00", o_rx_bits); end
      tests++; if (o_tx_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_tx_ready: got %b expected 0", o_tx_ready); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
      tests++; if (o_underflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_underflow: got %b expected 0", o_underflow); end
      i_rst = 1'b0;
      tick(5);
   endtask

   task automatic test_write();
      logic a0, a1, a2;
      int n0, p0;
      i_rx_ready = 1'b1;
      n0 = rx_log.size();
      p0 = rx_pulse_cnt;
      bus_start();
      send_byte(8'h84, a0);
      tests++; if (o_busy !== 1'b1) begin fails++; $display("[TB] FAIL write_busy: got %b expected 1", o_busy); end
      send_byte(8'hA5, a1);
      send_byte(8'h3C, a2);
      bus_stop();
      tests++; if ({a0, a1, a2} !== 3'b000) begin fails++; $display("[TB] FAIL write_acks: got %b expected 000", {a0, a1, a2}); end
      tests++; if (rx_log.size() - n0 !== 2) begin fails++; $display("[TB] FAIL write_count: got %0d expected 2", rx_log.size() - n0); end
      if (rx_log.size() - n0 >= 2) begin
         tests++; if (rx_log[n0] !== 8'hA5) begin fails++; $display("[TB] FAIL write_byte0: got %h expected A5", rx_log[n0]); end
         tests++; if (rx_log[n0+1] !== 8'h3C) begin fails++; $display("[TB] FAIL write_byte1: got %h expected 3C", rx_log[n0+1]); end
      end
      tests++; if (rx_pulse_cnt - p0 !== 2) begin fails++; $display("[TB] FAIL write_pulses: got %0d expected 2", rx_pulse_cnt - p0); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("[TB] FAIL write_idle: got busy %b expected 0", o_busy); end
   endtask

   task automatic test_addr_miss();
      logic a;
      int o0, b0;
      o0 = oe_cycles;
      b0 = busy_cycles;
      bus_start();
      send_byte(8'hA0, a);
      tests++; if (a !== 1'b1) begin fails++; $display("[TB] FAIL miss_nak: got %b expected 1", a); end
      bus_stop();
      tests++; if (oe_cycles - o0 !== 0) begin fails++; $display("[TB] FAIL miss_oe: got %0d driven cycles expected 0", oe_cycles - o0); end
      tests++; if (busy_cycles - b0 !== 0) begin fails++; $display("[TB] FAIL miss_busy: got %0d busy cycles expected 0", busy_cycles - b0); end
   endtask

   task automatic test_read();
      logic a;
      logic [7:0] d0, d1;
      int t0, u0;
      i_tx_valid = 1'b1;
      i_tx_bits  = 8'h5A;
      t0 = tx_ready_cnt;
      u0 = underflow_cnt;
      bus_start();
      send_byte(8'h85, a);
      i_tx_bits = 8'hC3;
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      tests++; if (a !== 1'b0) begin fails++; $display("[TB] FAIL read_addr_ack: got %b expected 0", a); end
      tests++; if (d0 !== 8'h5A) begin fails++; $display("[TB] FAIL read_byte0: got %h expected 5A", d0); end
      tests++; if (d1 !== 8'hC3) begin fails++; $display("[TB] FAIL read_byte1: got %h expected C3", d1); end
      tests++; if (tx_ready_cnt - t0 !== 2) begin fails++; $display("[TB] FAIL read_tx_ready: got %0d expected 2", tx_ready_cnt - t0); end
      tests++; if (underflow_cnt - u0 !== 0) begin fails++; $display("[TB] FAIL read_underflow: got %0d expected 0", underflow_cnt - u0); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("[TB] FAIL read_wait_stop: got busy %b expected 0", o_busy); end
      bus_stop();
   endtask

   task automatic test_underflow();
      logic a;
      logic [7:0] d;
      int t0, u0;
      i_tx_valid = 1'b0;
      t0 = tx_ready_cnt;
      u0 = underflow_cnt;
      bus_start();
      send_byte(8'h85, a);
      read_byte(1'b1, d);
      bus_stop();
      tests++; if (d !== 8'hFF) begin fails++; $display("[TB] FAIL underflow_byte: got %h expected FF", d); end
      tests++; if (underflow_cnt - u0 !== 1) begin fails++; $display("[TB] FAIL underflow_pulses: got %0d expected 1", underflow_cnt - u0); end
      tests++; if (tx_ready_cnt - t0 !== 1) begin fails++; $display("[TB] FAIL underflow_tx_ready: got %0d expected 1", tx_ready_cnt - t0); end
   endtask

   task automatic test_rx_stall();
      logic a0, a1, a2;
      i_rx_ready = 1'b0;
      bus_start();
      send_byte(8'h84, a0);
      send_byte(8'h11, a1);
      send_byte(8'h22, a2);
      bus_stop();
      tests++; if ({a0, a1, a2} !== 3'b001) begin fails++; $display("[TB] FAIL stall_acks: got %b expected 001", {a0, a1, a2}); end
      tests++; if (o_rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_valid: got %b expected 1", o_rx_valid); end
      tests++; if (o_rx_bits !== 8'h11) begin fails++; $display("[TB] FAIL stall_bits: got %h expected 11", o_rx_bits); end
      i_rx_ready = 1'b1;
      tick(1);
      tests++; if (o_rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_drain: got %b expected 0", o_rx_valid); end
   endtask

   task automatic test_back_to_back();
      logic a0, a1, a2, a3, a4, a5, r;
      logic [7:0] d;
      i_rx_ready = 1'b1;
      i_tx_valid = 1'b1;
      i_tx_bits  = 8'h96;
      bus_start();
      send_byte(8'h84, a0);
      send_byte(8'h5A, a1);
      bus_start();
      send_byte(8'h85, a2);
      read_byte(1'b1, d);
      bus_stop();
      tests++; if ({a0, a1, a2} !== 3'b000) begin fails++; $display("[TB] FAIL rstart_acks: got %b expected 000", {a0, a1, a2}); end
      tests++; if (d !== 8'h96) begin fails++; $display("[TB] FAIL rstart_read: got %h expected 96", d); end
      tests++; if (rx_log[$] !== 8'h5A) begin fails++; $display("[TB] FAIL rstart_write: got %h expected 5A", rx_log[$]); end

      i_tx_bits = 8'h00;
      bus_start();
      send_byte(8'h85, a3);
      for (int i = 0; i < 3; i++) bus_bit(1'b1, r);
      tests++; if (o_sda_oe !== 1'b1) begin fails++; $display("[TB] FAIL midbyte_drive: got %b expected 1", o_sda_oe); end
      i_rst = 1'b1;
      tick(1);
      tests++; if (o_sda_oe !== 1'b0) begin fails++; $display("[TB] FAIL midbyte_reset_oe: got %b expected 0", o_sda_oe); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("[TB] FAIL midbyte_reset_busy: got %b expected 0", o_busy); end
      i_rst = 1'b0;
      tick(5);
      bus_start();
      send_byte(8'h84, a4);
      send_byte(8'h77, a5);
      bus_stop();
      tests++; if ({a3, a4, a5} !== 3'b000) begin fails++; $display("[TB] FAIL post_reset_acks: got %b expected 000", {a3, a4, a5}); end
      tests++; if (rx_log[$] !== 8'h77) begin fails++; $display("[TB] FAIL post_reset_byte: got %h expected 77", rx_log[$]); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_addr_miss();
      test_read();
      test_underflow();
      test_rx_stall();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
